// File: rtl/counter_pkg.sv
// counter_pkg: direction and bound-mode constants shared by the counter slice
package counter_pkg;
    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/dff_r.sv
// dff_r: W-bit register with synchronous active-high reset to zero
module dff_r #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) q <= rst ? '0 : d;
endmodule

// File: rtl/updn_mod_counter.sv
// updn_mod_counter: up/down counter over 0..MAX_VAL with wrap or saturate at the bounds
module updn_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             sat
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_d;
    logic             ovf_d, sat_d;
    logic             at_top, at_bot;

    assign at_top = q == MAX;
    assign at_bot = q == '0;
    assign tc     = en & ((up_dn & at_top) | (~up_dn & at_bot));

    always_comb begin
        q_d   = q;
        ovf_d = 1'b0;
        sat_d = 1'b0;
        if (clear)
            q_d = '0;
        else if (load)
            q_d = (load_val > MAX) ? MAX : load_val;
        else if (en && up_dn == CNT_UP) begin
            if (!at_top)
                q_d = q + 1'b1;
            else if (sat_mode == MODE_SAT)
                sat_d = 1'b1;
            else begin
                q_d   = '0;
                ovf_d = 1'b1;
            end
        end else if (en) begin
            if (!at_bot)
                q_d = q - 1'b1;
            else if (sat_mode == MODE_SAT)
                sat_d = 1'b1;
            else begin
                q_d   = MAX;
                ovf_d = 1'b1;
            end
        end
    end

    dff_r #(.W(WIDTH)) u_q (.clk(clk), .rst(rst), .d(q_d), .q(q));
    dff_r #(.W(2)) u_flags (.clk(clk), .rst(rst), .d({ovf_d, sat_d}), .q({ovf, sat}));
endmodule

// File: tb/tb_updn_mod_counter.sv
// tb_updn_mod_counter: directed stimulus against an integer model of the counter rules
module tb_updn_mod_counter;
    localparam int W  = 4;
    localparam int MV = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1, clear = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         tc, ovf, sat;

    int checks = 0;
    int errors = 0;
    int mq = 0;
    bit movf = 1'b0, msat = 1'b0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    updn_mod_counter #(.WIDTH(W), .MAX_VAL(MV)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .q(q), .tc(tc), .ovf(ovf), .sat(sat)
    );

    // Reference behaviour in plain integer arithmetic
    always @(posedge clk) begin
        movf <= 1'b0;
        msat <= 1'b0;
        if (rst) mq <= 0;
        else if (clear) mq <= 0;
        else if (load) mq <= (int'(load_val) > MV) ? MV : int'(load_val);
        else if (en && up_dn) begin
            if (mq < MV) mq <= mq + 1;
            else if (sat_mode) msat <= 1'b1;
            else begin mq <= 0; movf <= 1'b1; end
        end else if (en) begin
            if (mq > 0) mq <= mq - 1;
            else if (sat_mode) msat <= 1'b1;
            else begin mq <= MV; movf <= 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit etc;
            etc = en && ((up_dn && mq == MV) || (!up_dn && mq == 0));
            checks += 4;
            if (int'(q) != mq) begin errors++; $display("FAIL model_q t=%0t got %0d want %0d", $time, q, mq); end
            if (ovf != movf) begin errors++; $display("FAIL model_ovf t=%0t got %0b want %0b", $time, ovf, movf); end
            if (sat != msat) begin errors++; $display("FAIL model_sat t=%0t got %0b want %0b", $time, sat, msat); end
            if (tc != etc) begin errors++; $display("FAIL model_tc t=%0t got %0b want %0b", $time, tc, etc); end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_q", int'(q), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_sat", int'(sat), 0);
        armed = 1'b1;
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        #1 chk("tc_after_rst", int'(tc), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("up_q%0d", i), int'(q), i % 10);
            chk($sformatf("up_ovf%0d", i), int'(ovf), int'(i == 10));
            chk($sformatf("up_tc%0d", i), int'(tc), int'(i % 10 == 9));
        end
        chk("model_pin_q2", mq, 2);
        clear = 1'b1;
        tick();
        chk("clear_q", int'(q), 0);
        clear = 1'b0; up_dn = 1'b0;
        #1 chk("tc_down_at0", int'(tc), 1);
        tick();
        chk("dn_wrap_q", int'(q), 9);
        chk("dn_wrap_ovf", int'(ovf), 1);
        chk("model_pin_ovf", int'(movf), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0; sat_mode = 1'b1;
        tick();
        chk("dn_sat_q", int'(q), 0);
        chk("dn_sat_flag", int'(sat), 1);
        tick();
        chk("dn_sat_q2", int'(q), 0);
        chk("dn_sat_flag2", int'(sat), 1);
        chk("dn_sat_ovf2", int'(ovf), 0);
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        tick();
        chk("load_clamp", int'(q), 9);
        chk("model_pin_clamp", mq, 9);
        chk("load_sat_clr", int'(sat), 0);
        load_val = 4'd5; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("load_over_en", int'(q), 5);
        clear = 1'b1; load_val = 4'd7;
        tick();
        chk("clear_over_load", int'(q), 0);
        clear = 1'b0; load_val = 4'd9; sat_mode = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("up_sat_q", int'(q), 9);
        chk("up_sat_flag", int'(sat), 1);
        rst = 1'b1; clear = 1'b1; load = 1'b1;
        tick();
        chk("rst_all_q", int'(q), 0);
        chk("rst_all_ovf", int'(ovf), 0);
        chk("rst_all_sat", int'(sat), 0);
        rst = 1'b0; clear = 1'b0; load = 1'b0; sat_mode = 1'b0;
        repeat (6) tick();
        chk("count6", int'(q), 6);
        rst = 1'b1;
        tick();
        chk("midrst_q", int'(q), 0);
        rst = 1'b0;
        tick();
        chk("resume_q", int'(q), 1);
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        #1 chk("tc_top_up", int'(tc), 1);
        up_dn = 1'b0;
        #1 chk("tc_top_dn", int'(tc), 0);
        tick();
        chk("turn_q", int'(q), 8);
        chk("turn_ovf", int'(ovf), 0);
        chk("turn_sat", int'(sat), 0);
        en = 1'b0;
        tick();
        chk("hold_q", int'(q), 8);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001: Parameter WIDTH, default 4, counter width in bits (WIDTH >= 2) SHALL be provided.
REQ-002: Parameter MAX_VAL, default 2**WIDTH-1, terminal value (1 <= MAX_VAL <= 2**WIDTH-1) SHALL be provided.
REQ-003: clk  input  1  rising-edge clock; all state SHALL update only on posedge clk.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: clear  input  1  synchronous clear request.
REQ-006: load  input  1  synchronous load request.
REQ-007: load_val  input  WIDTH  value applied on load.
REQ-008: en  input  1  count enable.
REQ-009: up_dn  input  1  direction; 1 = up, 0 = down.
REQ-010: sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds.
REQ-011: q  output  WIDTH  registered count value.
REQ-012: tc  output  1  combinational terminal-count flag.
REQ-013: ovf  output  1  registered one-cycle wrap pulse.
REQ-014: sat  output  1  registered one-cycle saturation-hold pulse.

Function
REQ-015: Per-edge priority SHALL be rst > clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-016: clear=1 -> q SHALL become 0 on the next edge; ovf, sat SHALL be 0 that cycle.
REQ-017: load=1 -> q SHALL become load_val; a load_val > MAX_VAL SHALL be clamped to MAX_VAL; ovf, sat SHALL be 0.
REQ-018: en=0 with no clear/load -> q SHALL hold; ovf, sat SHALL be 0.
REQ-019: en=1, up_dn=1, q < MAX_VAL -> q SHALL increment by 1, one-cycle latency.
REQ-020: en=1, up_dn=0, q > 0 -> q SHALL decrement by 1.
REQ-021: Up at q == MAX_VAL: sat_mode=0 -> q SHALL become 0 and ovf SHALL be 1 next cycle; sat_mode=1 -> q SHALL hold MAX_VAL and sat SHALL be 1 next cycle.
REQ-022: Down at q == 0: sat_mode=0 -> q SHALL become MAX_VAL and ovf SHALL be 1; sat_mode=1 -> q SHALL hold 0 and sat SHALL be 1.
REQ-023: ovf and sat SHALL be mutually exclusive and SHALL deassert after one cycle unless the bound event repeats (saturate: sat stays high while en held at bound).
REQ-024: tc SHALL equal en & ((up_dn & q==MAX_VAL) | (~up_dn & q==0)), independent of clear/load.
REQ-025: Arithmetic SHALL be WIDTH-bit; q SHALL never hold a value > MAX_VAL after any edge.
REQ-026: Changing up_dn or sat_mode mid-count SHALL take effect on the next edge with no extra latency.

Reset
REQ-027: rst=1 at an edge SHALL force q=0, ovf=0, sat=0, overriding all other inputs.
REQ-028: rst asserted mid-count SHALL lose the count; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-029: tc SHALL reflect the reset q value (0) in the cycle after reset.

Structure
REQ-030: Shared package counter_pkg SHALL hold the direction constants CNT_UP=1, CNT_DN=0 and mode constants MODE_WRAP=0, MODE_SAT=1.
REQ-031: State SHALL be held in one sub-module dff_r (parametrised WIDTH-bit register, synchronous active-high reset to 0), instantiated for q and for {ovf, sat}.
REQ-032: Next-state logic SHALL be a single combinational block feeding dff_r; no latches, no clock gating.

Verification (WIDTH=4, MAX_VAL=9)
REQ-033: rst=1 two cycles, then en=1, up_dn=1, sat_mode=0 for 12 cycles -> q 0..9,0,1,2; ovf=1 only in the cycle q returns to 0; tc=1 while q=9.
REQ-034: From q=0, en=1, up_dn=0, sat_mode=0 -> q=9 with ovf=1; then sat_mode=1 from q=0 -> q holds 0, sat=1 each held cycle.
REQ-035: load=1, load_val=13 -> q=9 next cycle; load=1, load_val=5 with en=1, up_dn=1 same cycle -> q=5, not 6.
REQ-036: clear=1 and load=1, load_val=7 same cycle -> q=0; rst=1 with clear, load, en all 1 -> q=0, ovf=0, sat=0.
REQ-037: Count up to q=6, assert rst one cycle -> q=0; release rst with en=1 -> q=1 next cycle.
REQ-038: At q=9, en=1, toggle up_dn to 0 -> tc drops same cycle, q=8 next edge, no ovf/sat.
